// File: rtl/inst_resp_unit.sv
// Instruction fetch responder: in-order request/response bridge to the memory read port,
// with a one-word last-fetch buffer that answers an idle-time refetch of the same word.
module inst_resp_unit #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        inv,
   output logic        mem_rd_req,
   output logic [31:0] mem_rd_addr,
   input  logic        mem_rd_gnt,
   input  logic        mem_rd_valid,
   input  logic [31:0] mem_rd_data
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_rq_valid;
   logic [31:0]      r_rq_addr;
   logic [29:0]      r_fifo [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_fcnt;
   logic             r_lb_valid;
   logic [29:0]      r_lb_tag;
   logic [31:0]      r_lb_data;
   logic             r_hit_pend;
   logic             r_mem_ok;
   logic [31:0]      r_rdata;

   logic w_accept;
   logic w_hit;
   logic w_miss;
   logic w_push;
   logic w_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // The buffer is only consulted when nothing is outstanding, so a hit can never
   // overtake an earlier miss still waiting on memory.
   assign inst_addr_ok = inst_req && !r_rq_valid && (r_cnt < DEPTH_C);
   assign w_accept     = inst_addr_ok;
   assign w_hit        = w_accept && (r_cnt == '0) && r_lb_valid
                         && (r_lb_tag == inst_addr[31:2]) && !inv;
   assign w_miss       = w_accept && !w_hit;
   assign w_push       = r_rq_valid && mem_rd_gnt;
   assign w_pop        = mem_rd_valid && (r_fcnt != '0);

   assign mem_rd_req   = r_rq_valid;
   assign mem_rd_addr  = r_rq_addr & 32'hFFFF_FFFC;
   assign inst_data_ok = r_hit_pend | r_mem_ok;
   // Buffer data cannot change during the hit cycle: no memory pop is possible then.
   assign inst_rdata   = r_hit_pend ? r_lb_data : r_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= '0;
         r_rq_valid <= 1'b0;
         r_rq_addr  <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fcnt     <= '0;
         r_lb_valid <= 1'b0;
         r_hit_pend <= 1'b0;
         r_mem_ok   <= 1'b0;
         r_rdata    <= '0;
      end else begin
         case ({w_accept, inst_data_ok})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase

         if (w_miss) begin
            r_rq_valid <= 1'b1;
            r_rq_addr  <= inst_addr;
         end else if (w_push) begin
            r_rq_valid <= 1'b0;
         end

         if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_fcnt <= r_fcnt + CNT_W'(1);
            2'b01:   r_fcnt <= r_fcnt - CNT_W'(1);
            default: r_fcnt <= r_fcnt;
         endcase

         r_hit_pend <= w_hit;
         r_mem_ok   <= w_pop;
         if (w_pop) r_rdata <= mem_rd_data;

         // Invalidate wins over a simultaneous buffer load.
         if (inv)        r_lb_valid <= 1'b0;
         else if (w_pop) r_lb_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= r_rq_addr[31:2];
      if (w_pop) begin
         r_lb_tag  <= r_fifo[r_rd_ptr];
         r_lb_data <= mem_rd_data;
      end
   end

endmodule

// File: tb/tb_inst_resp_unit.sv
// Directed bench for inst_resp_unit: expected responses queued at accept time and
// checked in order by an independent monitor on every inst_data_ok pulse.
module tb_inst_resp_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        inv;
   logic        mem_rd_req;
   logic [31:0] mem_rd_addr;
   logic        mem_rd_gnt;
   logic        mem_rd_valid;
   logic [31:0] mem_rd_data;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   inst_resp_unit #(.DEPTH(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .inv          (inv),
      .mem_rd_req   (mem_rd_req),
      .mem_rd_addr  (mem_rd_addr),
      .mem_rd_gnt   (mem_rd_gnt),
      .mem_rd_valid (mem_rd_valid),
      .mem_rd_data  (mem_rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every response pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (inst_data_ok === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: got rdata %h, required no response", inst_rdata);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (inst_rdata !== e) begin
               n_fail++;
               $display("FAIL resp_data: got %h, required %h", inst_rdata, e);
            end
         end
      end
   end

   task automatic request(input logic [31:0] a, input logic [31:0] exp_data);
      inst_req  = 1'b1;
      inst_addr = a;
      #1;
      chk("addr_ok_accept", {31'd0, inst_addr_ok}, 32'd1);
      exp_q.push_back(exp_data);
      tick();
      inst_req = 1'b0;
   endtask

   task automatic mem_return(input logic [31:0] d);
      mem_rd_valid = 1'b1;
      mem_rd_data  = d;
      tick();
      mem_rd_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; inst_req = 1'b0; inst_addr = '0; inv = 1'b0;
      mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
      tick();
      tick();
      chk("rst_data_ok", {31'd0, inst_data_ok}, 32'd0);
      chk("rst_rdata", inst_rdata, 32'd0);
      chk("rst_mem_req", {31'd0, mem_rd_req}, 32'd0);
      chk("rst_mem_addr", mem_rd_addr, 32'd0);
      reset = 1'b0;
      tick();

      // Cold miss
      request(32'hBFC0_0000, 32'h3C08_0001);
      chk("cold_mem_req", {31'd0, mem_rd_req}, 32'd1);
      chk("cold_mem_addr", mem_rd_addr, 32'hBFC0_0000);
      inst_req = 1'b1; inst_addr = 32'h0000_0040;
      #1;
      chk("blocked_by_rq", {31'd0, inst_addr_ok}, 32'd0);
      inst_req = 1'b0;
      mem_rd_gnt = 1'b1;
      tick();
      mem_rd_gnt = 1'b0;
      chk("cold_req_drop", {31'd0, mem_rd_req}, 32'd0);
      tick();
      tick();
      mem_return(32'h3C08_0001);
      chk("cold_pulse", {31'd0, inst_data_ok}, 32'd1);
      chk("cold_rdata", inst_rdata, 32'h3C08_0001);
      tick();
      chk("cold_single", {31'd0, inst_data_ok}, 32'd0);
      chk("cold_cnt", 32'(dut.r_cnt), 32'd0);

      // Hit from the last-fetch buffer
      request(32'hBFC0_0000, 32'h3C08_0001);
      chk("hit_pulse", {31'd0, inst_data_ok}, 32'd1);
      chk("hit_rdata", inst_rdata, 32'h3C08_0001);
      chk("hit_no_mem", {31'd0, mem_rd_req}, 32'd0);
      tick();
      chk("hit_no_mem2", {31'd0, mem_rd_req}, 32'd0);
      chk("hit_single", {31'd0, inst_data_ok}, 32'd0);

      // Invalidate forces the miss path; inv together with a load leaves buffer invalid
      inv = 1'b1;
      tick();
      inv = 1'b0;
      request(32'hBFC0_0000, 32'h1111_1111);
      chk("inv_no_hit", {31'd0, inst_data_ok}, 32'd0);
      chk("inv_mem_req", {31'd0, mem_rd_req}, 32'd1);
      chk("inv_mem_addr", mem_rd_addr, 32'hBFC0_0000);
      mem_rd_gnt = 1'b1;
      tick();
      mem_rd_gnt = 1'b0;
      inv = 1'b1;
      mem_return(32'h1111_1111);
      inv = 1'b0;
      chk("inv_pulse", {31'd0, inst_data_ok}, 32'd1);
      tick();
      chk("inv_beats_load", {31'd0, dut.r_lb_valid}, 32'd0);
      request(32'hBFC0_0003, 32'h2222_2222);
      chk("reload_miss", {31'd0, mem_rd_req}, 32'd1);
      chk("reload_aligned", mem_rd_addr, 32'hBFC0_0000);
      mem_rd_gnt = 1'b1;
      tick();
      mem_rd_gnt = 1'b0;
      mem_return(32'h2222_2222);
      tick();

      // Full and ordering
      request(32'h0000_0100, 32'h0000_000A);
      mem_rd_gnt = 1'b1;
      tick();
      mem_rd_gnt = 1'b0;
      request(32'h0000_0104, 32'h0000_000B);
      chk("full_mem_addr2", mem_rd_addr, 32'h0000_0104);
      mem_rd_gnt = 1'b1;
      tick();
      mem_rd_gnt = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h0000_0108;
      #1;
      chk("full_blocks", {31'd0, inst_addr_ok}, 32'd0);
      tick();
      chk("full_blocks2", {31'd0, inst_addr_ok}, 32'd0);
      inst_req = 1'b0;
      mem_return(32'h0000_000A);
      mem_return(32'h0000_000B);
      tick();
      tick();
      chk("lb_tag_last", 32'(dut.r_lb_tag), 32'h0000_0041);
      chk("full_cnt", 32'(dut.r_cnt), 32'd0);

      // Stray memory response with nothing outstanding
      mem_return(32'h0000_DEAD);
      chk("stray_ignored", {31'd0, inst_data_ok}, 32'd0);
      chk("stray_cnt", 32'(dut.r_cnt), 32'd0);

      // Reset while a read request is pending
      inst_req = 1'b1; inst_addr = 32'h0000_0200;
      #1;
      chk("pre_rst_accept", {31'd0, inst_addr_ok}, 32'd1);
      tick();
      inst_req = 1'b0;
      chk("pre_rst_req", {31'd0, mem_rd_req}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_req", {31'd0, mem_rd_req}, 32'd0);
      chk("mid_rst_cnt", 32'(dut.r_cnt), 32'd0);
      chk("mid_rst_addr", mem_rd_addr, 32'd0);
      mem_return(32'h0000_BEEF);
      chk("post_rst_stray", {31'd0, inst_data_ok}, 32'd0);
      tick();
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_resp_unit.md
# inst_resp_unit

Instruction-side memory responder that serves the pre-IF/IF request/response protocol: it takes `inst_req`/`inst_addr` with an `inst_addr_ok` handshake and returns exactly one `inst_data_ok` pulse with `inst_rdata` per accepted request, strictly in order. It sits between the fetch front end and the instruction read port of the memory subsystem. It keeps a one-word last-fetch buffer so that a back-to-back refetch of the same word, for example after a flush, is answered in one cycle without a memory access.

## Interface
- `DEPTH`, 2: maximum accepted requests without a response (hit and miss combined); must be 2 or greater.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inst_req`  in  1  requester has a valid fetch address.
- `inst_addr`  in  32  fetch virtual/physical address; bits [1:0] ignored.
- `inst_addr_ok`  out  1  combinational; request accepted this cycle.
- `inst_data_ok`  out  1  registered; one-cycle response pulse, no backpressure.
- `inst_rdata`  out  32  registered; valid when `inst_data_ok`.
- `inv`  in  1  invalidate the last-fetch buffer.
- `mem_rd_req`  out  1  read request to memory.
- `mem_rd_addr`  out  32  word-aligned read address, `{addr[31:2],2'b00}`.
- `mem_rd_gnt`  in  1  memory took the request this cycle.
- `mem_rd_valid`  in  1  read data returning; responses arrive in request order.
- `mem_rd_data`  in  32  read data.

## Operation
- State:
  - `cnt`, outstanding accepted requests, 0..DEPTH.
  - Request register `rq_valid`/`rq_addr`.
  - In-flight address FIFO of DEPTH entries, holding `addr[31:2]` of each granted miss.
  - Last-fetch buffer `lb_valid`/`lb_tag[29:0]`/`lb_data`.
  - `hit_pend` flag.
- `inst_addr_ok = inst_req && !rq_valid && cnt < DEPTH`.
- Hit condition on accept: `cnt==0 && lb_valid && lb_tag==inst_addr[31:2] && !inv`.
  - Hit: `hit_pend<=1`. The next cycle drives `inst_data_ok=1` and `inst_rdata=lb_data`. No memory access.
  - Miss: `rq_valid<=1`, `rq_addr<=inst_addr`.
- `mem_rd_req = rq_valid`. `mem_rd_addr` is aligned `rq_addr`.
- On `mem_rd_req && mem_rd_gnt`:
  - Clear `rq_valid`.
  - Push `rq_addr[31:2]` into the FIFO.
- On `mem_rd_valid` with the FIFO non-empty:
  - Pop the FIFO.
  - Next cycle: `inst_data_ok<=1`, `inst_rdata<=mem_rd_data`.
  - Load `lb_valid<=1`, `lb_tag<=popped tag`, `lb_data<=mem_rd_data`.
- `mem_rd_valid` with the FIFO empty is a protocol violation. Ignore it: no pulse, no state change.
- Counter: `cnt` +1 on accept, -1 on each `inst_data_ok` pulse. On the same cycle it is unchanged. It never exceeds DEPTH.
- `inv`:
  - Clears `lb_valid` at the next edge.
  - If a buffer load coincides with `inv`, `inv` wins and `lb_valid` becomes 0.
  - A hit in flight (`hit_pend` already set) still completes.
- No cancel input. Every accepted request receives exactly one `inst_data_ok`, and the requester discards unwanted ones.

## Timing
- Reset values (all registered outputs and state cleared in one cycle):
  - `inst_data_ok=0`, `inst_rdata=0`, `mem_rd_req=0`, `mem_rd_addr=0`.
  - `cnt=0`, FIFO empty, `lb_valid=0`, `hit_pend=0`.
- Reset mid-transaction drops all outstanding requests. Responses from memory after reset fall under the empty-FIFO ignore rule.
- Hit latency: accepted at T, `inst_data_ok` at T+1.
- Miss latency: accepted at T, `mem_rd_req` from T+1 until grant at G, memory valid at V>G. `inst_data_ok` is at V+1.
- Accept rate: at most one miss accept every 2 cycles (`rq_valid` blocks). Hits can be accepted back-to-back only when `cnt` returns to 0.
- While `rq_valid=1`, `mem_rd_req` and `mem_rd_addr` stay stable until granted.
- Full: `cnt==DEPTH` forces `inst_addr_ok=0`. An accept on the same cycle as a response is not allowed when `cnt==DEPTH`, because the check uses the registered `cnt`.

## Test plan
- Cold miss:
  - Stimulus: reset, then req addr 0xBFC00000, gnt same cycle as `mem_rd_req`, `mem_rd_valid` 3 cycles later with data 0x3C080001.
  - Response: exactly one `inst_data_ok` with rdata 0x3C080001, 1 cycle after valid; `cnt` back to 0.
- Hit:
  - Stimulus: after the cold miss, req 0xBFC00000 again with `cnt==0`.
  - Response: `inst_data_ok` next cycle with 0x3C080001; `mem_rd_req` never asserted.
- Invalidate:
  - Stimulus: `inv` pulse, then req 0xBFC00000.
  - Response: miss path; `mem_rd_req` with addr 0xBFC00000.
- Full and ordering:
  - Stimulus: DEPTH=2, two misses 0x100 and 0x104, memory withholds valid.
  - Response: `inst_addr_ok=0` on a third req.
  - Follow-up: returning 0xA then 0xB yields two ordered pulses 0xA, 0xB, and `lb_tag` equals 0x104>>2.
- Protocol edges:
  - Stimulus: `mem_rd_valid` with `cnt==0`.
  - Response: ignored.
  - Stimulus: reset asserted while `rq_valid=1`.
  - Response: `mem_rd_req=0` next cycle, `cnt=0`.
